kamus_fetch_buffer: RTL and testbench
=====================================

# kamus_fetch_buffer

Instruction fetch buffer between `kamus_IF` and the ID stage of the kamus-v core. It is a DEPTH-entry FIFO of {instruction, PC, misalign flag} with valid/ready handshakes on both sides. It decouples fetch from decode stalls and discards all buffered instructions on a control-flow redirect (flush). `in_ready_o` never depends combinationally on `out_ready_i`.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `out_instr_o` when empty (`addi x0,x0,0`).

Ports:
- `clk_i` in 1: core clock; all state updates on rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `flush_i` in 1: redirect from ID/EX; empties buffer.
- `in_valid_i` in 1: IF presents an instruction.
- `in_ready_o` out 1: buffer can accept this cycle.
- `in_instr_i` in 32: instruction word from $L1I via IF.
- `in_addr_i` in 32: PC of `in_instr_i`.
- `out_valid_o` out 1: head entry valid for ID.
- `out_ready_i` in 1: ID consumes head this cycle.
- `out_instr_o` out 32: head instruction.
- `out_addr_o` out 32: head PC.
- `out_misalign_o` out 1: head PC had bits [1:0] ≠ 0.
- `count_o` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Storage: DEPTH entries of {instr[31:0], addr[31:0], misalign}, with write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), and count register.
- Push when `in_valid_i && in_ready_o`: write entry at wptr; misalign = `|in_addr_i[1:0]`; wptr+1.
- Pop when `out_valid_o && out_ready_i`: rptr+1.
- `in_ready_o = (count < DEPTH) && !flush_i`.
- `out_valid_o = (count != 0)`.
- `out_*` are combinationally selected from the entry at rptr. When empty: `out_instr_o = NOP_INSTR`, `out_addr_o = 0`, `out_misalign_o = 0`.
- Count update: +1 on push only; −1 on pop only; unchanged on simultaneous push and pop.
- Flush: at the edge where `flush_i=1`, count, wptr and rptr become 0. Any push or pop in that cycle is discarded: `in_ready_o` is already 0, and a pop handshake has no effect beyond the clear. Flush has priority over everything except reset.
- The misalign flag is carried, not acted on; the ID stage raises the exception.
- Entry storage contents need no reset; only pointers and count are reset.

## Timing
- Reset (`rst_ni=0` at an edge): count=0, wptr=rptr=0. Next cycle: `out_valid_o=0`, `in_ready_o=1` (if `flush_i=0`), `out_instr_o=NOP_INSTR`, `out_addr_o=0`, `out_misalign_o=0`, `count_o=0`.
- Reset mid-operation discards all entries, identical to flush.
- Latency: an instruction pushed at edge N is visible on `out_*` with `out_valid_o=1` in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained. With `out_ready_i=1` continuously, count settles at 1 and never blocks IF.
- Full (count=DEPTH): `in_ready_o=0` even if `out_ready_i=1` in that cycle. `in_ready_o` returns to 1 in the cycle after the pop edge.
- Empty with a push and `out_ready_i=1` in the same cycle: no pop occurs (`out_valid_o=0`), so count becomes 1.
- Pointer wrap: DEPTH−1 → 0 with no gap or duplicate entry.
- Data on `out_*` is stable while `out_valid_o=1 && out_ready_i=0`, unless `flush_i` is asserted.

## Test plan
- Reset, then push {32'h0000_0093, 32'h0000_0000}: the cycle after the push, `out_valid_o=1`, `out_instr_o=32'h0000_0093`, `out_addr_o=0`, `count_o=1`. After the pop, `out_instr_o=32'h0000_0013`.
- `out_ready_i=0`, push PCs 0x0, 0x4, 0x8, 0xC (DEPTH=4): `count_o=4` and `in_ready_o=0`. A 5th `in_valid_i` is not accepted. Then `out_ready_i=1` for 4 cycles: PCs 0x0, 0x4, 0x8, 0xC come out in order, and `in_ready_o=1` from the cycle after the first pop.
- Streaming with both valids and readies at 1 for 20 cycles, PC incrementing by 4: each PC appears exactly once, in order, one cycle after its push. `count_o` stays at 1 and pointers wrap correctly.
- Fill 3 entries, then assert `flush_i` together with `in_valid_i` (PC 0x100) and `out_ready_i`: in that cycle `in_ready_o=0`. Next cycle `count_o=0` and `out_valid_o=0`. PC 0x100 never appears.
- Push `in_addr_i=32'h0000_0006`: `out_misalign_o=1` with `out_addr_o=32'h0000_0006`. The following push with PC 0x8 gives `out_misalign_o=0`.
- Assert `rst_ni=0` for one edge while holding 2 entries: next cycle all outputs are at their reset values. Normal operation resumes on the following push.

Source files
------------

// File: rtl/kamus_fetch_buffer.sv
// kamus_fetch_buffer: DEPTH-entry FIFO between IF and ID.
// Each entry holds {instruction, PC, misalign flag}. A flush (redirect) or reset
// discards all buffered entries. in_ready_o depends only on occupancy and flush_i,
// never on out_ready_i, so a full buffer cannot accept even when ID pops that cycle.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                control-flow redirect, empties the buffer
//   in_valid_i/in_ready_o  IF-side handshake; in_instr_i, in_addr_i payload
//   out_valid_o/out_ready_i ID-side handshake; out_instr_o, out_addr_o, out_misalign_o
//   count_o                number of occupied entries
module kamus_fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [31:0]                in_addr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_misalign_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     instr_q    [DEPTH];
  logic [31:0]     addr_q     [DEPTH];
  logic            misalign_q [DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;

  assign in_ready_o  = (count_q < CntW'(DEPTH)) && !flush_i;
  assign out_valid_o = (count_q != '0);

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  assign out_instr_o    = out_valid_o ? instr_q[rptr_q]    : NOP_INSTR;
  assign out_addr_o     = out_valid_o ? addr_q[rptr_q]     : 32'h0;
  assign out_misalign_o = out_valid_o ? misalign_q[rptr_q] : 1'b0;
  assign count_o        = count_q;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flush outranks any handshake in the same cycle; a pop there only clears.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; out_valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wptr_q]    <= in_instr_i;
      addr_q[wptr_q]     <= in_addr_i;
      misalign_q[wptr_q] <= |in_addr_i[1:0];
    end
  end

endmodule

// File: tb/tb_kamus_fetch_buffer.sv
// Self-checking bench for kamus_fetch_buffer. A queue-based reference model tracks
// the buffer contents; directed scenarios check against fixed values and a random
// phase checks every output against the model each cycle.
module tb_kamus_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [31:0] in_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_misalign_o;
  logic [2:0]  count_o;

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  kamus_fetch_buffer #(
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_instr_i     (in_instr_i),
    .in_addr_i      (in_addr_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_instr_o    (out_instr_o),
    .out_addr_o     (out_addr_o),
    .out_misalign_o (out_misalign_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model expectations derived from queue occupancy and head entry.
  function automatic logic m_valid();
    return model_q.size() != 0;
  endfunction
  function automatic logic m_ready();
    return (model_q.size() < DEPTH) && !flush_i;
  endfunction
  function automatic logic [31:0] m_instr();
    return (model_q.size() != 0) ? model_q[0].instr : NOP;
  endfunction
  function automatic logic [31:0] m_addr();
    return (model_q.size() != 0) ? model_q[0].addr : 32'h0;
  endfunction
  function automatic logic m_mis();
    logic [31:0] a;
    a = m_addr();
    return (model_q.size() != 0) && (a % 4 != 0);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    entry_t e;
    bit     do_push;
    bit     do_pop;
    @(posedge clk_i);
    if (!rst_ni || flush_i) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && out_ready_i;
      do_push = (model_q.size() < DEPTH) && in_valid_i;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.instr = in_instr_i;
        e.addr  = in_addr_i;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] addr,
                       input logic rdy, input logic fl);
    in_valid_i  = v;
    in_instr_i  = instr;
    in_addr_i   = addr;
    out_ready_i = rdy;
    flush_i     = fl;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    n_checks++; if (out_instr_o !== NOP) begin n_fail++;
      $display("FAIL reset_instr: got %h want %h", out_instr_o, NOP); end
    n_checks++; if (out_addr_o !== 32'h0) begin n_fail++;
      $display("FAIL reset_addr: got %h want 0", out_addr_o); end
    n_checks++; if (out_misalign_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_misalign: got %b want 0", out_misalign_o); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", count_o); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0093, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL single_valid: got %b want 1", out_valid_o); end
    n_checks++; if (out_instr_o !== 32'h0000_0093) begin n_fail++;
      $display("FAIL single_instr: got %h want 00000093", out_instr_o); end
    n_checks++; if (out_addr_o !== 32'h0) begin n_fail++;
      $display("FAIL single_addr: got %h want 0", out_addr_o); end
    n_checks++; if (count_o !== 3'd1) begin n_fail++;
      $display("FAIL single_count: got %0d want 1", count_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    #1;
    n_checks++; if (out_instr_o !== NOP || out_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL single_after_pop: got instr %h valid %b want %h valid 0",
               out_instr_o, out_valid_o, NOP); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hdead_beef, 32'h10, 1'b0, 1'b0);
    #1;
    n_checks++; if (count_o !== 3'd4) begin n_fail++;
      $display("FAIL full_count: got %0d want 4", count_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++;
      $display("FAIL full_ready: got %b want 0", in_ready_o); end
    out_ready_i = 1'b1;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++;
      $display("FAIL full_ready_with_pop: got %b want 0", in_ready_o); end
    out_ready_i = 1'b0;
    tick();
    #1;
    n_checks++; if (count_o !== 3'd4) begin n_fail++;
      $display("FAIL full_5th_rejected: count got %0d want 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      n_checks++; if (out_addr_o !== 32'(i * 4) || out_valid_o !== 1'b1) begin n_fail++;
        $display("FAIL full_drain_order %0d: got addr %h valid %b want %h valid 1",
                 i, out_addr_o, out_valid_o, i * 4); end
      tick();
      if (i == 0) begin
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++;
          $display("FAIL full_ready_after_pop: got %b want 1", in_ready_o); end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL full_drained: valid got %b want 0", out_valid_o); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    pc = 32'h200;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, pc, 1'b1, 1'b0);
      #1;
      n_checks++; if (in_ready_o !== 1'b1) begin n_fail++;
        $display("FAIL stream_ready %0d: got %b want 1", i, in_ready_o); end
      if (i > 0) begin
        n_checks++; if (out_valid_o !== 1'b1 || out_addr_o !== pc - 32'd4) begin n_fail++;
          $display("FAIL stream_order %0d: got addr %h valid %b want %h valid 1",
                   i, out_addr_o, out_valid_o, pc - 32'd4); end
        n_checks++; if (count_o !== 3'd1) begin n_fail++;
          $display("FAIL stream_count %0d: got %0d want 1", i, count_o); end
      end
      tick();
      pc += 32'd4;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    #1;
    n_checks++; if (count_o !== 3'd0) begin n_fail++;
      $display("FAIL stream_drain: count got %0d want 0", count_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h0000_0113, 32'h100, 1'b1, 1'b1);
    #1;
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++;
      $display("FAIL flush_ready: got %b want 0", in_ready_o); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL flush_clear: got count %0d valid %b want 0 0", count_o, out_valid_o); end
    tick();
    #1;
    n_checks++; if (out_valid_o !== 1'b0 || out_addr_o === 32'h100) begin n_fail++;
      $display("FAIL flush_no_leak: got valid %b addr %h want 0 0", out_valid_o, out_addr_o); end
  endtask

  task automatic test_misalign();
    drive(1'b1, $urandom, 32'h6, 1'b0, 1'b0);
    tick();
    drive(1'b1, $urandom, 32'h8, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (out_misalign_o !== 1'b1 || out_addr_o !== 32'h6) begin n_fail++;
      $display("FAIL misalign_set: got mis %b addr %h want 1 00000006",
               out_misalign_o, out_addr_o); end
    out_ready_i = 1'b1;
    tick();
    #1;
    n_checks++; if (out_misalign_o !== 1'b0 || out_addr_o !== 32'h8) begin n_fail++;
      $display("FAIL misalign_clear: got mis %b addr %h want 0 00000008",
               out_misalign_o, out_addr_o); end
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    n_checks++; if (out_valid_o !== 1'b0 || count_o !== 3'd0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got valid %b count %0d ready %b want 0 0 1",
               out_valid_o, count_o, in_ready_o); end
    n_checks++; if (out_instr_o !== NOP || out_addr_o !== 32'h0 || out_misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_data: got %h %h %b want %h 0 0",
               out_instr_o, out_addr_o, out_misalign_o, NOP); end
    drive(1'b1, 32'h0000_0193, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (out_valid_o !== 1'b1 || out_addr_o !== 32'h400 || count_o !== 3'd1) begin
      n_fail++;
      $display("FAIL midreset_resume: got valid %b addr %h count %0d want 1 00000400 1",
               out_valid_o, out_addr_o, count_o); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_ni = ($urandom_range(63) != 0);
      drive(($urandom_range(3) != 0), $urandom, $urandom, ($urandom_range(2) != 0),
            ($urandom_range(15) == 0));
      #1;
      n_checks++; if (in_ready_o !== m_ready()) begin n_fail++;
        $display("FAIL rand_ready %0d: got %b want %b", i, in_ready_o, m_ready()); end
      n_checks++; if (out_valid_o !== m_valid()) begin n_fail++;
        $display("FAIL rand_valid %0d: got %b want %b", i, out_valid_o, m_valid()); end
      n_checks++; if (out_instr_o !== m_instr()) begin n_fail++;
        $display("FAIL rand_instr %0d: got %h want %h", i, out_instr_o, m_instr()); end
      n_checks++; if (out_addr_o !== m_addr()) begin n_fail++;
        $display("FAIL rand_addr %0d: got %h want %h", i, out_addr_o, m_addr()); end
      n_checks++; if (out_misalign_o !== m_mis()) begin n_fail++;
        $display("FAIL rand_misalign %0d: got %b want %b", i, out_misalign_o, m_mis()); end
      n_checks++; if (count_o !== 3'(model_q.size())) begin n_fail++;
        $display("FAIL rand_count %0d: got %0d want %0d", i, count_o, model_q.size()); end
      tick();
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
